// File: rtl/dram_store_buffer_if.sv
// Store-side and memory-side handshake bundle for dram_store_buffer.
// The buffer uses the slave view; the store producer and memory model use master.
interface dram_store_buffer_if #(
  parameter int XLEN = 32
);
  logic              st_valid;
  logic              st_ready;
  logic [31:0]       st_addr;
  logic [XLEN-1:0]   st_data;
  logic [3:0]        st_type;
  logic              st_err;
  logic              mem_valid;
  logic              mem_ready;
  logic [31:0]       mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wmask;

  modport master (
    output st_valid, st_addr, st_data, st_type, mem_ready,
    input  st_ready, st_err, mem_valid, mem_addr, mem_wdata, mem_wmask
  );
  modport slave (
    input  st_valid, st_addr, st_data, st_type, mem_ready,
    output st_ready, st_err, mem_valid, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/dram_store_buffer.sv
// In-order store buffer: aligns/masks stores into a DEPTH-entry FIFO feeding memory.
// Define DRAM_STBUF_COALESCE_EN to merge same-word stores into the youngest non-head entry.
module dram_store_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  dram_store_buffer_if.slave       bus,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]     addr;
    logic [XLEN-1:0] wdata;
    logic [NB-1:0]   wmask;
  } entry_t;

  entry_t        ent_q [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          err_q;

  logic [OW-1:0] offset;
  logic [3:0]    size;
  logic [15:0]   size_mask;
  logic          st_ok, accept, alloc, deq;
  entry_t        new_ent;

  always_comb begin
    offset = bus.st_addr[OW-1:0];
    unique case (bus.st_type)
      4'b0001: size = 4'd1;
      4'b0010: size = 4'd2;
      4'b0100: size = 4'd4;
      4'b1000: size = (XLEN == 64) ? 4'd8 : 4'd0;
      default: size = 4'd0;
    endcase
    // size==0 marks an illegal type, so only alignment remains to check
    st_ok     = (size != 4'd0) && ((4'(offset) & (size - 4'd1)) == 4'd0);
    size_mask = (16'd1 << size) - 16'd1;
    new_ent.addr  = {bus.st_addr[31:OW], {OW{1'b0}}};
    new_ent.wdata = bus.st_data << {offset, 3'b000};
    new_ent.wmask = NB'(size_mask << offset);
  end

  assign accept = bus.st_valid && bus.st_ready;
  assign deq    = bus.mem_valid && bus.mem_ready;

`ifdef DRAM_STBUF_COALESCE_EN
  logic [PW-1:0]   last_ptr;
  logic            merge;
  logic [XLEN-1:0] bmask;

  // count>=2 keeps the youngest entry off the head, so it cannot be draining now
  assign last_ptr = wr_ptr - PW'(1);
  assign merge    = accept && st_ok && (count >= CW'(2)) &&
                    (ent_q[last_ptr].addr == new_ent.addr);
  assign alloc    = accept && st_ok && !merge;

  always_comb begin
    for (int i = 0; i < NB; i++) bmask[8*i +: 8] = {8{new_ent.wmask[i]}};
  end
`else
  assign alloc = accept && st_ok;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      err_q <= accept && !st_ok;
      if (alloc) begin
        ent_q[wr_ptr] <= new_ent;
        wr_ptr        <= wr_ptr + PW'(1);
      end
`ifdef DRAM_STBUF_COALESCE_EN
      if (merge) begin
        ent_q[last_ptr].wdata <= (ent_q[last_ptr].wdata & ~bmask) | (new_ent.wdata & bmask);
        ent_q[last_ptr].wmask <= ent_q[last_ptr].wmask | new_ent.wmask;
      end
`endif
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(alloc) - CW'(deq);
    end
  end

  assign bus.st_ready  = count < CW'(DEPTH);
  assign bus.st_err    = err_q;
  assign bus.mem_valid = count != '0;
  assign bus.mem_addr  = ent_q[rd_ptr].addr;
  assign bus.mem_wdata = ent_q[rd_ptr].wdata;
  assign bus.mem_wmask = ent_q[rd_ptr].wmask;
endmodule

// File: tb/tb_dram_store_buffer.sv
// Bench for dram_store_buffer: queue-based reference model on a 32-bit instance,
// directed literal checks on 32-bit and 64-bit instances.
module tb_dram_store_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dram_store_buffer_if #(.XLEN(32)) i32 ();
  dram_store_buffer_if #(.XLEN(64)) i64 ();
  logic [2:0] count32, count64;

  dram_store_buffer #(.XLEN(32), .DEPTH(4)) u32 (.clk(clk), .rst(rst), .bus(i32.slave), .count(count32));
  dram_store_buffer #(.XLEN(64), .DEPTH(4)) u64 (.clk(clk), .rst(rst), .bus(i64.slave), .count(count64));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model of the 32-bit instance: a plain queue of {addr,data,mask}
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } ment_t;
  ment_t m_q[$];
  bit    m_err   = 1'b0;
  bit    m_ever  = 1'b0;

  initial begin : compare_proc
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("count", count32, m_q.size());
      chk("st_ready", i32.st_ready, m_q.size() < 4);
      chk("mem_valid", i32.mem_valid, m_q.size() != 0);
      chk("st_err", i32.st_err, m_err);
      if (m_q.size() != 0) begin
        chk("mem_addr", i32.mem_addr, m_q[0].a);
        chk("mem_wdata", i32.mem_wdata, m_q[0].d);
        chk("mem_wmask", i32.mem_wmask, m_q[0].m);
      end else if (!m_ever) begin
        chk("idle_zero", {i32.mem_addr, i32.mem_wdata}, 64'd0);
        chk("idle_mask", i32.mem_wmask, 4'd0);
      end
      // advance the model with the inputs the next rising edge will sample
      if (rst) begin
        m_q.delete();
        m_err  = 1'b0;
        m_ever = 1'b0;
      end else begin
        automatic bit          acc = i32.st_valid && (m_q.size() < 4);
        automatic bit          dq  = (m_q.size() != 0) && i32.mem_ready;
        automatic int          sz  = 0;
        automatic int          off = i32.st_addr % 4;
        automatic bit          ok;
        automatic ment_t       e;
        case (i32.st_type)
          4'd1: sz = 1;
          4'd2: sz = 2;
          4'd4: sz = 4;
          4'd8: sz = 8;
          default: sz = 0;
        endcase
        ok    = (sz == 1 || sz == 2 || sz == 4) && (off % sz == 0);
        m_err = acc && !ok;
        if (acc && ok) begin
          e.a = i32.st_addr - 32'(off);
          e.d = 32'(i32.st_data << (8 * off));
          e.m = 4'(((1 << sz) - 1) << off);
`ifdef DRAM_STBUF_COALESCE_EN
          if (m_q.size() >= 2 && m_q[m_q.size()-1].a == e.a) begin
            for (int b = 0; b < 4; b++)
              if (e.m[b]) m_q[m_q.size()-1].d[8*b +: 8] = e.d[8*b +: 8];
            m_q[m_q.size()-1].m = m_q[m_q.size()-1].m | e.m;
          end else
`endif
          begin
            m_q.push_back(e);
            m_ever = 1'b1;
          end
        end
        if (dq) void'(m_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] t);
    i32.st_valid = v;
    i32.st_addr  = a;
    i32.st_data  = d;
    i32.st_type  = t;
  endtask

  initial begin : stim_proc
    drive32(1'b0, 32'd0, 32'd0, 4'd0);
    i32.mem_ready = 1'b0;
    i64.st_valid = 1'b0; i64.st_addr = '0; i64.st_data = '0; i64.st_type = '0; i64.mem_ready = 1'b0;
    rst = 1'b1;
    step(); step();
    chk("rst_count", count32, 0);
    chk("rst_ready", i32.st_ready, 1);
    chk("rst_mvalid", i32.mem_valid, 0);
    chk("rst_maddr", i32.mem_addr, 0);
    rst = 1'b0;

    // byte store into the top lane of a word
    i32.mem_ready = 1'b1;
    drive32(1'b1, 32'h8000_0003, 32'h0000_00AB, 4'b0001);
    step();
    drive32(1'b0, 32'd0, 32'd0, 4'd0);
    chk("sb_valid", i32.mem_valid, 1);
    chk("sb_addr", i32.mem_addr, 32'h8000_0000);
    chk("sb_wdata", i32.mem_wdata, 32'hAB00_0000);
    chk("sb_wmask", i32.mem_wmask, 4'b1000);
    step();

    // misaligned halfword is rejected
    drive32(1'b1, 32'h8000_0001, 32'h1234, 4'b0010);
    step();
    drive32(1'b0, 32'd0, 32'd0, 4'd0);
    chk("err_pulse", i32.st_err, 1);
    chk("err_count", count32, 0);
    chk("err_mvalid", i32.mem_valid, 0);
    step();
    chk("err_clear", i32.st_err, 0);

    // fill with memory stalled, then drain in order
    i32.mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive32(1'b1, 32'h1000 + 32'(4 * i), 32'(i + 1), 4'b0100);
      step();
      if (i == 3) begin
        chk("full_ready", i32.st_ready, 0);
        chk("full_count", count32, 4);
      end
    end
    chk("full_hold", count32, 4);
    drive32(1'b0, 32'd0, 32'd0, 4'd0);
    i32.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_addr", i32.mem_addr, 32'h1000 + 32'(4 * i));
      chk("drain_data", i32.mem_wdata, 32'(i + 1));
      step();
    end
    chk("drain_count", count32, 0);

    // same-word bytes behind a stalled head
    i32.mem_ready = 1'b0;
    drive32(1'b1, 32'h8000_0100, 32'hCAFE_F00D, 4'b0100); step();
    drive32(1'b1, 32'h8000_0104, 32'h11, 4'b0001); step();
    drive32(1'b1, 32'h8000_0105, 32'h22, 4'b0001); step();
    drive32(1'b0, 32'd0, 32'd0, 4'd0);
`ifdef DRAM_STBUF_COALESCE_EN
    chk("coal_count", count32, 2);
`else
    chk("coal_count", count32, 3);
`endif
    i32.mem_ready = 1'b1;
    step();
`ifdef DRAM_STBUF_COALESCE_EN
    chk("coal_mask", i32.mem_wmask, 4'b0011);
    chk("coal_data", i32.mem_wdata[15:0], 16'h2211);
`else
    chk("coal_mask", i32.mem_wmask, 4'b0001);
    chk("coal_data", i32.mem_wdata[15:0], 16'h0011);
`endif
    step(); step();
    chk("coal_empty", count32, 0);

    // reset mid-operation with a handshake in the reset cycle
    i32.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive32(1'b1, 32'h2000 + 32'(4 * i), 32'(i), 4'b0100);
      step();
    end
    chk("pre_rst_count", count32, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive32(1'b0, 32'd0, 32'd0, 4'd0);
    chk("mid_rst_count", count32, 0);
    chk("mid_rst_mvalid", i32.mem_valid, 0);
    chk("mid_rst_ready", i32.st_ready, 1);
    chk("mid_rst_err", i32.st_err, 0);

    // 64-bit lanes
    i64.st_valid = 1'b1; i64.st_addr = 32'h10; i64.st_data = 64'h1122_3344_5566_7788; i64.st_type = 4'b1000;
    step();
    chk("sd_err", i64.st_err, 0);
    chk("sd_addr", i64.mem_addr, 32'h10);
    chk("sd_wdata", i64.mem_wdata, 64'h1122_3344_5566_7788);
    chk("sd_wmask", i64.mem_wmask, 8'hFF);
    i64.st_addr = 32'h15; i64.st_data = 64'h5A; i64.st_type = 4'b0001;
    step();
    i64.st_valid = 1'b0;
    chk("sb64_count", count64, 2);
    i64.mem_ready = 1'b1;
    step();
    chk("sb64_addr", i64.mem_addr, 32'h10);
    chk("sb64_wdata", i64.mem_wdata, 64'h0000_5A00_0000_0000);
    chk("sb64_wmask", i64.mem_wmask, 8'h20);
    step();
    chk("sb64_empty", count64, 0);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      automatic logic [3:0] types [8] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd0, 4'd3, 4'd1, 4'd4};
      drive32($urandom_range(0, 9) < 7, 32'h8000_0000 + 32'($urandom_range(0, 15)),
              $urandom, types[$urandom_range(0, 7)]);
      i32.mem_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    drive32(1'b0, 32'd0, 32'd0, 4'd0);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
